// File: rtl/uart_bus_master_if.sv
// Memory-bus bundle between the UART bridge (initiator) and a bus slave.
`timescale 1ns/1ps
interface uart_bus_master_if;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;

   modport master (
      output mem_valid, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/uart_bus_master.sv
// UART-to-memory-bus bridge: 8N1 receiver/transmitter plus a command parser
// that turns 'W'/'R' serial commands into single bus transactions.
`timescale 1ns/1ps
module uart_bus_master #(
   parameter int unsigned CKDIV    = 868,
   parameter int unsigned FRAME_TO = 16,
   parameter int unsigned BUS_TO   = 1024
) (
   input  logic                      clk,
   input  logic                      rst_n,
   uart_bus_master_if.master         bus,
   input  logic                      uart_rxd,
   output logic                      uart_txd,
   output logic                      busy
);
   localparam logic [15:0] DIV_M1  = 16'(CKDIV - 1);
   localparam logic [15:0] HALF_M1 = 16'(CKDIV / 2 - 1);
   localparam logic [31:0] FTO_M1  = 32'(FRAME_TO * CKDIV - 1);
   localparam logic [31:0] BTO_M1  = 32'(BUS_TO - 1);
   localparam logic [7:0]  CMD_W = 8'h57, CMD_R = 8'h52;
   localparam logic [7:0]  RSP_K = 8'h4B, RSP_E = 8'h45, RSP_Q = 8'h3F;

   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
   typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, P_BUS, P_RESP} p_state_t;

   logic        rxd_meta_q, rxd_sync_q;
   rx_state_t   rx_state_q, rx_state_d;
   logic [15:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_sh_q, rx_sh_d, rx_byte_q, rx_byte_d;
   logic        rx_stb_q, rx_stb_d;
   logic        tx_act_q, tx_act_d, txd_q, txd_d;
   logic [15:0] tx_cnt_q, tx_cnt_d;
   logic [3:0]  tx_bit_q, tx_bit_d;
   logic [8:0]  tx_sh_q, tx_sh_d;
   logic        tx_last_s, tx_take_s;
   p_state_t    p_state_q, p_state_d;
   logic [1:0]  p_cnt_q, p_cnt_d, resp_left_q, resp_left_d;
   logic        is_wr_q, is_wr_d, valid_q, valid_d, busy_q, busy_d;
   logic [31:0] to_cnt_q, to_cnt_d, addr_q, addr_d, wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [23:0] resp_sh_q, resp_sh_d;
   logic        tx_vld_q, tx_vld_d;
   logic [7:0]  tx_byte_q, tx_byte_d;

   // Two-flop synchronizer for the asynchronous serial input (idles high).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxd_meta_q <= 1'b1;
         rxd_sync_q <= 1'b1;
      end else begin
         rxd_meta_q <= uart_rxd;
         rxd_sync_q <= rxd_meta_q;
      end
   end

   // Receiver: start validation at half bit, centre sampling, stop/framing check.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_byte_d  = rx_byte_q;
      rx_stb_d   = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (!rxd_sync_q) begin
               rx_state_d = RX_START;
               rx_cnt_d   = 16'd0;
            end else begin
               rx_state_d = RX_IDLE;
            end
         end
         RX_START: begin
            if (rx_cnt_q == HALF_M1) begin
               rx_cnt_d   = 16'd0;
               rx_bit_d   = 3'd0;
               rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + 16'd1;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == DIV_M1) begin
               rx_cnt_d = 16'd0;
               rx_sh_d  = {rxd_sync_q, rx_sh_q[7:1]};
               if (rx_bit_q == 3'd7) begin
                  rx_state_d = RX_STOP;
               end else begin
                  rx_bit_d = rx_bit_q + 3'd1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + 16'd1;
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == DIV_M1) begin
               rx_cnt_d = 16'd0;
               if (rxd_sync_q) begin
                  rx_stb_d   = 1'b1;
                  rx_byte_d  = rx_sh_q;
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_state_d = RX_WAIT;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + 16'd1;
            end
         end
         RX_WAIT: begin
            // Framing error: stay disarmed until the line returns high.
            if (rxd_sync_q) begin
               rx_state_d = RX_IDLE;
            end else begin
               rx_state_d = RX_WAIT;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // Transmitter takes a new byte when idle or in the last cycle of a stop
   // bit, so queued response bytes leave with no idle gap; tx_last_s is the
   // one-cycle end-of-stop-bit (tx done) strobe.
   assign tx_last_s = tx_act_q && (tx_bit_q == 4'd9) && (tx_cnt_q == DIV_M1);
   assign tx_take_s = tx_vld_q && (!tx_act_q || tx_last_s);

   // Transmitter: start bit, 8 data bits LSB first, stop bit, CKDIV clocks each.
   always_comb begin
      tx_act_d = tx_act_q;
      tx_cnt_d = tx_cnt_q;
      tx_bit_d = tx_bit_q;
      tx_sh_d  = tx_sh_q;
      txd_d    = txd_q;
      if (tx_take_s) begin
         tx_act_d = 1'b1;
         tx_cnt_d = 16'd0;
         tx_bit_d = 4'd0;
         tx_sh_d  = {1'b1, tx_byte_q};
         txd_d    = 1'b0;
      end else if (tx_act_q) begin
         if (tx_cnt_q == DIV_M1) begin
            tx_cnt_d = 16'd0;
            if (tx_bit_q == 4'd9) begin
               tx_act_d = 1'b0;
               txd_d    = 1'b1;
            end else begin
               tx_bit_d = tx_bit_q + 4'd1;
               txd_d    = tx_sh_q[0];
               tx_sh_d  = {1'b1, tx_sh_q[8:1]};
            end
         end else begin
            tx_cnt_d = tx_cnt_q + 16'd1;
         end
      end else begin
         txd_d = 1'b1;
      end
   end

   // Command parser: collects fields, runs the bus cycle, queues the response.
   always_comb begin
      p_state_d   = p_state_q;
      p_cnt_d     = p_cnt_q;
      is_wr_d     = is_wr_q;
      to_cnt_d    = to_cnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      valid_d     = valid_q;
      wstrb_d     = wstrb_q;
      resp_sh_d   = resp_sh_q;
      resp_left_d = resp_left_q;
      tx_vld_d    = tx_vld_q;
      tx_byte_d   = tx_byte_q;
      case (p_state_q)
         P_IDLE: begin
            if (rx_stb_q) begin
               p_cnt_d  = 2'd0;
               to_cnt_d = 32'd0;
               case (rx_byte_q)
                  CMD_W: begin
                     is_wr_d   = 1'b1;
                     p_state_d = P_ADDR;
                  end
                  CMD_R: begin
                     is_wr_d   = 1'b0;
                     p_state_d = P_ADDR;
                  end
                  default: begin
                     p_state_d   = P_RESP;
                     tx_vld_d    = 1'b1;
                     tx_byte_d   = RSP_Q;
                     resp_left_d = 2'd0;
                  end
               endcase
            end else begin
               p_state_d = P_IDLE;
            end
         end
         P_ADDR, P_DATA: begin
            if (rx_stb_q) begin
               to_cnt_d = 32'd0;
               p_cnt_d  = p_cnt_q + 2'd1;
               if (p_state_q == P_ADDR) begin
                  addr_d[{p_cnt_q, 3'b000} +: 8] = rx_byte_q;
               end else begin
                  wdata_d[{p_cnt_q, 3'b000} +: 8] = rx_byte_q;
               end
               if (p_cnt_q == 2'd3) begin
                  p_state_d = (p_state_q == P_ADDR && is_wr_q) ? P_DATA : P_BUS;
               end else begin
                  p_state_d = p_state_q;
               end
            end else if (to_cnt_q == FTO_M1) begin
               // Line went quiet mid-command: drop the partial command silently.
               p_state_d = P_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + 32'd1;
            end
         end
         P_BUS: begin
            if (!valid_q) begin
               valid_d  = 1'b1;
               wstrb_d  = is_wr_q ? 4'hF : 4'h0;
               to_cnt_d = 32'd0;
            end else if (bus.mem_ready) begin
               valid_d   = 1'b0;
               wstrb_d   = 4'h0;
               p_state_d = P_RESP;
               tx_vld_d  = 1'b1;
               if (is_wr_q) begin
                  tx_byte_d   = RSP_K;
                  resp_left_d = 2'd0;
               end else begin
                  tx_byte_d   = bus.mem_rdata[7:0];
                  resp_sh_d   = bus.mem_rdata[31:8];
                  resp_left_d = 2'd3;
               end
            end else if (to_cnt_q == BTO_M1) begin
               valid_d     = 1'b0;
               wstrb_d     = 4'h0;
               p_state_d   = P_RESP;
               tx_vld_d    = 1'b1;
               tx_byte_d   = RSP_E;
               resp_left_d = 2'd0;
            end else begin
               to_cnt_d = to_cnt_q + 32'd1;
            end
         end
         P_RESP: begin
            if (tx_take_s) begin
               if (resp_left_q == 2'd0) begin
                  tx_vld_d = 1'b0;
               end else begin
                  tx_byte_d   = resp_sh_q[7:0];
                  resp_sh_d   = {8'h00, resp_sh_q[23:8]};
                  resp_left_d = resp_left_q - 2'd1;
               end
            end else if (!tx_vld_q && tx_last_s) begin
               p_state_d = P_IDLE;
            end else begin
               p_state_d = P_RESP;
            end
         end
         default: p_state_d = P_IDLE;
      endcase
      busy_d = (p_state_d != P_IDLE);
   end

   // State and registered outputs for receiver, transmitter and parser.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state_q  <= RX_IDLE;
         rx_cnt_q    <= 16'd0;
         rx_bit_q    <= 3'd0;
         rx_sh_q     <= 8'h00;
         rx_byte_q   <= 8'h00;
         rx_stb_q    <= 1'b0;
         tx_act_q    <= 1'b0;
         tx_cnt_q    <= 16'd0;
         tx_bit_q    <= 4'd0;
         tx_sh_q     <= 9'h1FF;
         txd_q       <= 1'b1;
         p_state_q   <= P_IDLE;
         p_cnt_q     <= 2'd0;
         is_wr_q     <= 1'b0;
         to_cnt_q    <= 32'd0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         valid_q     <= 1'b0;
         wstrb_q     <= 4'h0;
         resp_sh_q   <= 24'd0;
         resp_left_q <= 2'd0;
         tx_vld_q    <= 1'b0;
         tx_byte_q   <= 8'h00;
         busy_q      <= 1'b0;
      end else begin
         rx_state_q  <= rx_state_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_bit_q    <= rx_bit_d;
         rx_sh_q     <= rx_sh_d;
         rx_byte_q   <= rx_byte_d;
         rx_stb_q    <= rx_stb_d;
         tx_act_q    <= tx_act_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_bit_q    <= tx_bit_d;
         tx_sh_q     <= tx_sh_d;
         txd_q       <= txd_d;
         p_state_q   <= p_state_d;
         p_cnt_q     <= p_cnt_d;
         is_wr_q     <= is_wr_d;
         to_cnt_q    <= to_cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         valid_q     <= valid_d;
         wstrb_q     <= wstrb_d;
         resp_sh_q   <= resp_sh_d;
         resp_left_q <= resp_left_d;
         tx_vld_q    <= tx_vld_d;
         tx_byte_q   <= tx_byte_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.mem_valid = valid_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_wstrb = wstrb_q;
   assign uart_txd      = txd_q;
   assign busy          = busy_q;
endmodule

// File: tb/tb_uart_bus_master.sv
// Scoreboard bench for uart_bus_master: a reference model predicts bus
// transactions and response bytes; bus and UART monitors check them.
`timescale 1ns/1ps
module tb_uart_bus_master;
   localparam int CKDIV = 8, FRAME_TO = 16, BUS_TO = 16;

   logic clk = 1'b0, rst_n = 1'b0, uart_rxd = 1'b1;
   logic uart_txd, busy;
   uart_bus_master_if bus ();

   uart_bus_master #(.CKDIV(CKDIV), .FRAME_TO(FRAME_TO), .BUS_TO(BUS_TO)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .uart_rxd(uart_rxd), .uart_txd(uart_txd), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0, n_pass = 0, cyc = 0;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      bit          is_wr;
      int          cycles;
   } bus_exp_t;

   bus_exp_t    exp_bus[$];
   logic [7:0]  exp_tx[$];
   logic [31:0] slave_mem[logic [31:0]];
   logic [31:0] ref_mem[logic [31:0]];
   logic [31:0] used_addr[$];
   int          slave_lat = 0;

   // ---------------- slave model: responds lat cycles after valid, -1 = never
   int s_cnt = 0;
   always @(negedge clk) begin
      if (bus.mem_valid) begin
         if (slave_lat >= 0 && s_cnt == slave_lat) begin
            bus.mem_ready = 1'b1;
            bus.mem_rdata = slave_mem.exists(bus.mem_addr) ? slave_mem[bus.mem_addr] : ~bus.mem_addr;
            if (bus.mem_wstrb == 4'hF) slave_mem[bus.mem_addr] = bus.mem_wdata;
         end else begin
            bus.mem_ready = 1'b0;
            bus.mem_rdata = $urandom;
         end
         s_cnt++;
      end else begin
         s_cnt = 0;
         bus.mem_ready = ($urandom_range(0, 3) == 0);  // stray ready must be ignored
         bus.mem_rdata = $urandom;
      end
   end

   // ---------------- bus monitor
   bit in_txn = 1'b0, have_cur = 1'b0;
   int b_cycles = 0;
   bus_exp_t cur;
   always @(negedge clk) begin
      if (!rst_n) begin
         in_txn = 1'b0;
      end else if (bus.mem_valid) begin
         if (!in_txn) begin
            in_txn   = 1'b1;
            b_cycles = 1;
            chk("bus_txn_expected", 32'(exp_bus.size() != 0), 32'd1);
            have_cur = (exp_bus.size() != 0);
            if (have_cur) cur = exp_bus.pop_front();
         end else begin
            b_cycles++;
         end
         if (have_cur) begin
            chk("bus_addr", bus.mem_addr, cur.addr);
            chk("bus_wstrb", 32'(bus.mem_wstrb), 32'(cur.wstrb));
            if (cur.is_wr) chk("bus_wdata", bus.mem_wdata, cur.wdata);
         end
      end else if (in_txn) begin
         in_txn = 1'b0;
         chk("bus_wstrb_cleared", 32'(bus.mem_wstrb), 32'd0);
         if (have_cur) chk("bus_valid_cycles", 32'(b_cycles), 32'(cur.cycles));
      end
   end

   // ---------------- UART TX monitor
   int last_start = -100000;
   initial begin
      forever begin
         int start;
         logic [7:0] b;
         @(negedge uart_txd);
         start = cyc;
         repeat (CKDIV / 2) @(negedge clk);
         chk("tx_start_bit", 32'(uart_txd), 32'd0);
         for (int i = 0; i < 8; i++) begin
            repeat (CKDIV) @(negedge clk);
            b[i] = uart_txd;
         end
         repeat (CKDIV) @(negedge clk);
         chk("tx_stop_bit", 32'(uart_txd), 32'd1);
         if (start - last_start < 20 * CKDIV)
            chk("tx_frame_spacing", 32'(start - last_start), 32'(10 * CKDIV));
         last_start = start;
         chk("tx_byte_expected", 32'(exp_tx.size() != 0), 32'd1);
         if (exp_tx.size() != 0) chk("tx_byte", 32'(b), 32'(exp_tx.pop_front()));
      end
   end

   // ---------------- stimulus helpers
   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      @(negedge clk);
      uart_rxd = 1'b0;
      repeat (CKDIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         repeat (CKDIV) @(negedge clk);
      end
      uart_rxd = stop_bit;
      repeat (CKDIV) @(negedge clk);
      uart_rxd = 1'b1;
      if (!stop_bit) repeat (CKDIV) @(negedge clk);
   endtask

   task automatic glitch();
      @(negedge clk);
      uart_rxd = 1'b0;
      repeat (2) @(negedge clk);
      uart_rxd = 1'b1;
      repeat (2 * CKDIV) @(negedge clk);
   endtask

   task automatic wait_idle();
      int k = 0;
      while (k < 80 * CKDIV && (exp_tx.size() != 0 || busy !== 1'b0)) begin
         @(negedge clk);
         k++;
      end
      chk("idle_reached", 32'(exp_tx.size() == 0 && busy === 1'b0), 32'd1);
      repeat (2 * CKDIV) @(negedge clk);
   endtask

   function automatic bit completes(input int lat);
      return (lat >= 0 && lat < BUS_TO);
   endfunction

   // ---------------- reference model + command issue
   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int lat);
      bus_exp_t e;
      e.addr = a; e.wdata = d; e.wstrb = 4'hF; e.is_wr = 1'b1;
      e.cycles = completes(lat) ? lat + 1 : BUS_TO;
      exp_bus.push_back(e);
      if (completes(lat)) begin
         ref_mem[a] = d;
         exp_tx.push_back(8'h4B);
      end else begin
         exp_tx.push_back(8'h45);
      end
      used_addr.push_back(a);
      slave_lat = lat;
      send_byte(8'h57, 1'b1);
      for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b1);
      for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], 1'b1);
      wait_idle();
   endtask

   task automatic do_read(input logic [31:0] a, input int lat, input bit with_glitch);
      bus_exp_t e;
      logic [31:0] v;
      e.addr = a; e.wdata = 32'd0; e.wstrb = 4'h0; e.is_wr = 1'b0;
      e.cycles = completes(lat) ? lat + 1 : BUS_TO;
      exp_bus.push_back(e);
      v = ref_mem.exists(a) ? ref_mem[a] : ~a;
      if (completes(lat)) begin
         for (int i = 0; i < 4; i++) exp_tx.push_back(v[8*i +: 8]);
      end else begin
         exp_tx.push_back(8'h45);
      end
      slave_lat = lat;
      send_byte(8'h52, 1'b1);
      for (int i = 0; i < 4; i++) begin
         if (with_glitch && i == 1) begin
            glitch();
            chk("glitch_mid_cmd_busy", 32'(busy), 32'd1);
         end
         send_byte(a[8*i +: 8], 1'b1);
      end
      wait_idle();
   endtask

   task automatic do_bad(input logic [7:0] b);
      exp_tx.push_back(8'h3F);
      send_byte(b, 1'b1);
      wait_idle();
   endtask

   function automatic int rand_lat();
      int r;
      r = $urandom_range(0, 5);
      if (r < 4) return r;
      else if (r == 4) return BUS_TO - 1;
      else return -1;
   endfunction

   // ---------------- watchdog
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, checks %0d passed %0d", n_checks, n_pass);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence
   initial begin
      @(negedge clk);
      chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
      chk("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
      chk("rst_uart_txd", 32'(uart_txd), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4 * CKDIV) @(negedge clk);

      // Directed: write with ready 3 cycles after valid
      do_write(32'h4000_0010, 32'hDEAD_BEEF, 3);
      // Directed: read with immediate ready, 4 back-to-back response bytes
      slave_mem[32'h4000_0004] = 32'h1234_5678;
      ref_mem[32'h4000_0004]   = 32'h1234_5678;
      do_read(32'h4000_0004, 0, 1'b0);
      // Bus timeout on write, then a normal read, then read of the timed-out address
      do_write(32'h4000_0020, 32'hCAFE_F00D, -1);
      do_read(32'h4000_0010, 1, 1'b0);
      do_read(32'h4000_0020, 2, 1'b0);

      // Unknown command, framing error, partial command with inter-byte timeout
      do_bad(8'h00);
      send_byte(8'h55, 1'b0);
      repeat (4 * CKDIV) @(negedge clk);
      chk("framing_err_busy", 32'(busy), 32'd0);
      send_byte(8'h52, 1'b1);
      repeat (8 * CKDIV) @(negedge clk);
      chk("partial_cmd_busy", 32'(busy), 32'd1);
      repeat ((FRAME_TO - 8 + 2) * CKDIV) @(negedge clk);
      chk("partial_cmd_timeout", 32'(busy), 32'd0);
      do_read(32'h4000_0004, 0, 1'b0);

      // Start glitches: in idle and in the middle of a command
      glitch();
      repeat (4 * CKDIV) @(negedge clk);
      chk("glitch_idle_busy", 32'(busy), 32'd0);
      do_read(32'h4000_0010, 2, 1'b1);

      // Reset in the middle of a bus cycle
      begin
         bus_exp_t e;
         int k;
         e.addr = 32'h0000_0100; e.wdata = 32'h0BAD_0BAD; e.wstrb = 4'hF; e.is_wr = 1'b1;
         e.cycles = BUS_TO;
         exp_bus.push_back(e);
         slave_lat = -1;
         send_byte(8'h57, 1'b1);
         for (int i = 0; i < 4; i++) send_byte(e.addr[8*i +: 8], 1'b1);
         for (int i = 0; i < 4; i++) send_byte(e.wdata[8*i +: 8], 1'b1);
         k = 0;
         while (k < 4 * CKDIV && bus.mem_valid !== 1'b1) begin
            @(negedge clk);
            k++;
         end
         chk("valid_before_reset", 32'(bus.mem_valid), 32'd1);
         #2 rst_n = 1'b0;
         #1;
         chk("async_rst_valid", 32'(bus.mem_valid), 32'd0);
         chk("async_rst_busy", 32'(busy), 32'd0);
         chk("async_rst_txd", 32'(uart_txd), 32'd1);
         chk("async_rst_wstrb", 32'(bus.mem_wstrb), 32'd0);
         repeat (3) @(negedge clk);
         rst_n = 1'b1;
         repeat (20 * CKDIV) @(negedge clk);
         chk("post_rst_busy", 32'(busy), 32'd0);
      end

      // Randomised command mix
      for (int n = 0; n < 12; n++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 4) begin
            do_write($urandom, $urandom, rand_lat());
         end else if (r < 8) begin
            logic [31:0] a;
            if (used_addr.size() != 0 && $urandom_range(0, 1) == 1)
               a = used_addr[$urandom_range(0, used_addr.size() - 1)];
            else
               a = $urandom;
            do_read(a, rand_lat(), 1'b0);
         end else begin
            logic [7:0] b;
            b = 8'($urandom);
            while (b == 8'h57 || b == 8'h52) b = 8'($urandom);
            do_bad(b);
         end
      end

      repeat (4 * CKDIV) @(negedge clk);
      chk("tx_queue_drained", 32'(exp_tx.size()), 32'd0);
      chk("bus_queue_drained", 32'(exp_bus.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- UART-to-memory-bus bridge. A host PC drives the design's internal bus over a serial line: load programs, peek/poke peripherals such as the UART block itself.
- Bus initiator: issues mem_valid/mem_ready transactions toward the same slave interface the peripherals implement.
- Self-contained 8N1 bit-level receiver and transmitter with a fixed baud divider, plus a command parser FSM.

Parameters:
- CKDIV, 868, clk cycles per UART bit (legal range 4..65535).
- FRAME_TO, 16, inter-byte timeout in bit times while a command is partially received.
- BUS_TO, 1024, clk cycles to wait for mem_ready before aborting a transaction.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- mem_valid  output  1  bus request, held until mem_ready
- mem_ready  input  1  slave completion strobe
- mem_addr  output  32  bus address
- mem_wdata  output  32  write data
- mem_wstrb  output  4  byte strobes; 4'hF write, 4'h0 read
- mem_rdata  input  32  read data, valid in the mem_ready cycle
- uart_rxd  input  1  serial in, asynchronous to clk
- uart_txd  output  1  serial out, idles high
- busy  output  1  high whenever the parser is not in IDLE

Behaviour:
- Reset (asynchronous, active-low; clk and rst_n as above): all outputs go to their reset values immediately: mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, uart_txd=1, busy=0. Reset mid-transaction abandons it; no response byte is sent.
- RX front end:
  - uart_rxd passes through a 2-flop synchronizer (reset value 1).
  - A falling edge in idle starts a frame. The line is re-sampled at CKDIV/2; if it is high, the start is false and the receiver returns to idle.
  - Then 8 data bits LSB first, each sampled at the centre of its bit, then a stop bit.
  - Stop bit = 0 is a framing error: the byte is discarded and the receiver waits for the line to go high before re-arming.
  - A good byte produces a 1-cycle rx_stb.
- TX back end:
  - When loaded, sends start(0), 8 data bits LSB first, stop(1); each bit lasts exactly CKDIV cycles.
  - tx_done pulses for 1 cycle at the end of the stop bit.
  - Back-to-back bytes have no idle gap.
- Protocol (multi-byte fields little-endian):
  - 0x57 'W' + A0..A3 + D0..D3: 32-bit write; response 0x4B 'K'.
  - 0x52 'R' + A0..A3: 32-bit read; response R0..R3.
  - Any other command byte: response 0x3F '?'; parser returns to IDLE.
  - Bus timeout on either command: response 0x45 'E'.
- Parser FSM states:
  - IDLE: a command byte moves to ADDR (W/R) or RESP ('?').
  - ADDR: 2-bit counter 0..3. After A3, go to DATA for W, BUS for R.
  - DATA: counter 0..3. After D3, go to BUS.
  - BUS:
    - mem_valid rises the cycle after entry. mem_addr, mem_wdata and mem_wstrb are stable for the whole time mem_valid is high.
    - The first cycle with mem_valid=1 and mem_ready=1 completes the transaction. mem_valid drops the next cycle and mem_rdata is captured in that ready cycle.
    - mem_ready while mem_valid=0 is ignored.
    - BUS_TO cycles with no ready: mem_valid drops and the response is 'E'.
  - RESP: sends 1 or 4 bytes, then goes to IDLE.
- mem_addr is passed through unaligned; the slave decides what to do with it. mem_wstrb returns to 0 with mem_valid.
- Inter-byte timeout: in ADDR or DATA, if no rx_stb arrives within FRAME_TO*CKDIV cycles since the last byte, go silently to IDLE and discard the partial command.
- Bytes received while in BUS or RESP are dropped. The receiver keeps framing so that it stays bit-synchronised.
- Counters:
  - Bit-timer width is 16 bits.
  - Timeout counters saturate and reset on every state entry.

Test Plan:
- CKDIV=8, BUS_TO=16. Send 57 10 00 00 40 EF BE AD DE; slave gives ready 3 cycles after valid -> exactly one transaction with mem_addr=0x40000010, mem_wdata=0xDEADBEEF, mem_wstrb=F, mem_valid high for 4 cycles; TX emits 0x4B.
- Send 52 04 00 00 40; slave returns mem_rdata=0x12345678 with ready on the first cycle -> mem_wstrb=0, mem_valid high 1 cycle; TX emits 78 56 34 12, each frame 80 clk with no gaps.
- Write command with mem_ready tied 0 -> mem_valid high exactly 16 cycles then 0; TX emits 0x45; the next read command completes normally.
- Send 0x00, then a frame with stop bit 0, then 0x52 followed by nothing -> '?' response for 0x00; framing-error byte ignored; after 16 bit times busy=0 with no bus cycle; a fresh full read then succeeds.
- Assert rst_n=0 in the middle of the BUS state with mem_valid=1 -> mem_valid and busy go to 0 and uart_txd to 1 asynchronously; no response byte after release.
- Start glitch of 2 clk low on uart_rxd -> no byte received; parser state unchanged.
